// File: rtl/mux_rr_sched.sv
// Round-robin scheduler that steers a 32:1 mux select, samples the mux output and hands it downstream.
// Define MUX_SCHED_GCNT_EN to add the saturating completed-transfer counter output gcnt.
module mux_rr_sched #(
  parameter int DW   = 2,
  parameter int NREQ = 31
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [4:0]      sel,
  input  logic [DW-1:0]   mux_out,
  output logic [NREQ-1:0] ack,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_data,
  output logic [4:0]      out_src
`ifdef MUX_SCHED_GCNT_EN
  ,
  output logic [15:0]     gcnt
`endif
);

  typedef enum logic [1:0] {IDLE, GRANT, HOLD} state_t;

  state_t          state_reg, state_next;
  logic [4:0]      sel_reg, sel_next;
  logic [4:0]      ptr_reg, ptr_next;
  logic [4:0]      src_reg, src_next;
  logic            valid_reg, valid_next;
  logic [DW-1:0]   data_reg, data_next;

  logic            handshake;
  logic            win_found;
  logic [4:0]      win_idx;
  logic [5:0]      cand;

  assign handshake = valid_reg & out_ready;

  // Scan downward in distance so the closest set bit after ptr is the one that sticks.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = {1'b0, ptr_reg} + 6'(k);
      if (cand >= 6'(NREQ)) cand = cand - 6'(NREQ);
      if (req[cand[4:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[4:0];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    ptr_next   = ptr_reg;
    src_next   = src_reg;
    valid_next = valid_reg;
    data_next  = data_reg;
    case (state_reg)
      IDLE: begin
        if (win_found) begin
          sel_next   = win_idx;
          src_next   = win_idx;
          state_next = GRANT;
        end
      end
      GRANT: begin
        // A request withdrawn before sampling aborts silently and keeps the old pointer.
        if (req[sel_reg]) begin
          data_next  = mux_out;
          valid_next = 1'b1;
          state_next = HOLD;
        end else begin
          state_next = IDLE;
        end
      end
      HOLD: begin
        if (handshake) begin
          valid_next = 1'b0;
          ptr_next   = src_reg;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      sel_reg   <= '0;
      ptr_reg   <= 5'(NREQ - 1);
      src_reg   <= '0;
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
      ptr_reg   <= ptr_next;
      src_reg   <= src_next;
      valid_reg <= valid_next;
      data_reg  <= data_next;
    end
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_ack
    assign ack[gi] = handshake && (src_reg == 5'(gi));
  end

  assign sel       = sel_reg;
  assign out_valid = valid_reg;
  assign out_data  = data_reg;
  assign out_src   = src_reg;

`ifdef MUX_SCHED_GCNT_EN
  logic [15:0] gcnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gcnt_reg <= '0;
    end else if (handshake && gcnt_reg != 16'hFFFF) begin
      gcnt_reg <= gcnt_reg + 16'd1;
    end
  end

  assign gcnt = gcnt_reg;
`endif

endmodule

// File: doc/mux_rr_sched.md
MUX_RR_SCHED -- requirements
Module: mux_rr_sched

Interface
REQ-001 SHALL have parameter DW, default 2: data width of the sampled mux output.
REQ-002 SHALL have parameter NREQ, default 31: number of requesters, fixed to select indices 0..30.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port req, input, NREQ: per-requester request, level, held until ack.
REQ-006 SHALL have port sel, output, 5: select driven to the 32:1 mux.
REQ-007 SHALL have port mux_out, input, DW: combinational output of the mux for the current sel.
REQ-008 SHALL have port ack, output, NREQ: one-hot, one-cycle pulse to the requester whose transfer completes.
REQ-009 SHALL have port out_valid, output, 1: out_data/out_src valid.
REQ-010 SHALL have port out_ready, input, 1: downstream accepts when high with out_valid.
REQ-011 SHALL have port out_data, output, DW: registered sample of mux_out.
REQ-012 SHALL have port out_src, output, 5: index of the requester that produced out_data.

Function
REQ-013 SHALL implement FSM states IDLE, GRANT, HOLD.
REQ-014 IDLE: if req != 0, SHALL pick winner = first set bit searching upward from ptr+1, wrapping 30->0; load sel=winner, out_src=winner; go GRANT; else stay in IDLE with sel unchanged.
REQ-015 GRANT: if req[sel]=1, SHALL register out_data<=mux_out, set out_valid=1, go HOLD; if req[sel]=0, SHALL abort to IDLE with no output and no ptr update.
REQ-016 HOLD: SHALL hold sel, out_data, out_src, out_valid stable until out_ready=1.
REQ-017 HOLD with out_ready=1: SHALL clear out_valid next cycle, pulse ack[out_src] for exactly that handshake cycle (combinational on out_valid&out_ready), set ptr<=out_src, go IDLE.
REQ-018 Latency: req seen in IDLE at cycle N -> sel updated at N+1 -> out_valid=1 at N+2; minimum 3 cycles per transfer with out_ready tied high.
REQ-019 sel SHALL only take values 0..30; 31 is never driven.
REQ-020 req changes in HOLD SHALL not affect the in-flight transfer; a dropped req in HOLD still completes.
REQ-021 Multiple simultaneous requests SHALL be served round-robin; a continuously asserted requester waits at most 30 transfers.
REQ-022 req bits above NREQ-1 do not exist; no X SHALL propagate to sel from an all-zero req.

Reset
REQ-023 rst=1 SHALL asynchronously force state=IDLE, sel=0, ptr=30, out_valid=0, out_data=0, out_src=0, ack=0.
REQ-024 rst mid-transfer (GRANT or HOLD) SHALL discard the transfer without an ack; first post-reset winner is the lowest set req index.

Configuration
REQ-025 With macro MUX_SCHED_GCNT_EN defined, SHALL add output gcnt[15:0], reset to 0, incrementing by 1 on each completed handshake, saturating at 16'hFFFF.
REQ-026 Without MUX_SCHED_GCNT_EN, port gcnt and its counter SHALL be absent; all other behaviour identical.

Verification
REQ-027 req=0x0000_0001 after reset, mux_out=2'b10, out_ready=1 -> sel=0 at N+1, out_valid=1 with out_data=2, out_src=0 at N+2, ack[0] pulses at N+2.
REQ-028 req bits 3, 12, 30 held, out_ready=1 -> out_src sequence 3,12,30,3; sel never 31.
REQ-029 req[5]=1, out_ready=0 for 10 cycles then 1 -> out_valid/out_data/sel stable for 10 cycles, single ack[5] on the release cycle.
REQ-030 req[7] asserted then dropped during GRANT -> return to IDLE, no out_valid, no ack, next winner search still starts from old ptr+1.
REQ-031 rst pulsed asynchronously in HOLD -> out_valid=0, sel=0, no ack same cycle; then req bits 0 and 1 -> winner 0.
REQ-032 With MUX_SCHED_GCNT_EN, 5 completed transfers -> gcnt=5; forced to 16'hFFFF then one more transfer -> gcnt stays 16'hFFFF.
